fin_period_meter: RTL and testbench
===================================

// Module: fin_period_meter
// PURPOSE
//  Parametrised successor to the single-channel fin period counter. Measures an asynchronous
//  input fin in clk cycles: full period, legacy half period, high time or low time.
//  Optionally averages over 2^AVG_LOG2 measurements and saturates with an overflow flag.
//  Sits between the pad-level fin input and the frequency/control logic that consumes count_N.
// PARAMETERS
//  CNT_W       16  width of the measurement counter and of count_N
//  AVG_LOG2    0   log2 of the number of measurements averaged per result (0..4)
//  SYNC_STAGES 2   synchronizer flops on fin (>=2)
// PORTS
//  clk      in   1      system clock; the only clock
//  reset    in   1      synchronous, active-high reset
//  fin      in   1      asynchronous input to be measured
//  enable   in   1      1 = measure; 0 = abort and go idle
//  mode     in   2      00 full period, 01 half period, 10 high time, 11 low time
//  count_N  out  CNT_W  latest result, held until the next result
//  valid    out  1      1-cycle pulse when count_N updates
//  overflow out  1      1 = latest result saturated
//  busy     out  1      1 = state != IDLE
// BEHAVIOUR
//  - Reset: count_N=0, valid=0, overflow=0, busy=0, state IDLE, sync flops/cnt/acc/win=0.
//  - Sync: fin passes through SYNC_STAGES flops plus one delay flop.
//    rise = s & ~d; fall = ~s & d.
//  - Edge lag: a pin edge is detected SYNC_STAGES+1 clk later.
//    valid rises the cycle after stop-edge detection.
//  - Edges per mode. Start edge: rise for 00/01/10, fall for 11.
//    Stop edge: rise for 00/01/11, fall for 10.
//  - mode is latched at IDLE->ARM and at each window start.
//    A mode change takes effect at the next averaging window.
//  - FSM:
//    IDLE: enable=1 -> ARM.
//    ARM: start edge -> MEAS, cnt<=0.
//    MEAS: cnt++ each cycle; stop edge -> sample=cnt+1 (clk cycles between edge detections).
//  - After a stop edge:
//    modes 00/01 stay in MEAS, cnt<=0; the stop edge is the next start edge (back-to-back).
//    modes 10/11 -> ARM.
//  - Averaging: acc (CNT_W+AVG_LOG2 bits) += sample; win++.
//    When win reaches 2^AVG_LOG2: count_N<=acc>>AVG_LOG2, further >>1 in mode 01 (truncate).
//    Also: valid=1, overflow<=0, acc<=0, win<=0.
//  - Saturation: in MEAS, if cnt+1 == 2^CNT_W-1 and no stop edge that cycle:
//    count_N<=all-ones (mode 01 too), overflow<=1, valid=1, acc/win cleared, -> ARM.
//    A stop edge in that same cycle wins: normal result 2^CNT_W-1.
//  - overflow is sticky until the next non-saturated result.
//  - enable=0 in any state -> IDLE next cycle. cnt/acc/win cleared; no valid; count_N/overflow hold.
//  - reset mid-measurement: as reset; no valid pulse.
//  - Start and stop edge in the same cycle cannot occur for the high/low modes (distinct polarities).
//    For full-period modes this is the back-to-back case above.
// STRUCTURE
//  - Package fin_period_meter_pkg: state enum {IDLE, ARM, MEAS}; mode constants
//    MODE_PERIOD, MODE_HALF, MODE_HIGH, MODE_LOW.
//  - Sub-module fin_sync_edge #(SYNC_STAGES): synchronizer + delay flop; outputs lvl, rise, fall.
//  - Top: FSM, counter, accumulator, output registers.
// TESTING
//  1 Reset 3 cycles mid-activity -> count_N=0, valid=0, overflow=0, busy=0. Idle fin -> no valid.
//  2 Mode 00, AVG_LOG2=0, fin 10 high/10 low -> valid every 20 clk, count_N=20.
//    Mode 01 same fin -> count_N=10.
//  3 Mode 10, fin 7 high/13 low -> count_N=7 once per period. Mode 11 -> count_N=13.
//  4 AVG_LOG2=2, mode 00, periods 10,12,10,12 -> exactly one valid, after the 4th period, count_N=11.
//  5 CNT_W=8, rise then fin held low -> valid 255 clk after start detection, count_N=255, overflow=1.
//    Next period of 20 -> count_N=20, overflow=0.
//  6 enable dropped mid-period -> busy=0 next cycle, no valid, count_N holds.
//    Re-enable -> first result after a fresh start edge.

Source files
------------

// File: rtl/fin_period_meter_pkg.sv
// rtl/fin_period_meter_pkg.sv - shared state encoding and measurement mode constants
package fin_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [1:0] MODE_PERIOD = 2'b00;
   localparam logic [1:0] MODE_HALF   = 2'b01;
   localparam logic [1:0] MODE_HIGH   = 2'b10;
   localparam logic [1:0] MODE_LOW    = 2'b11;

   // Rise-to-rise modes: the stop edge of one sample is the start edge of the next.
   function automatic logic is_periodic(input logic [1:0] m);
      return (m == MODE_PERIOD) || (m == MODE_HALF);
   endfunction

endpackage

// File: rtl/fin_sync_edge.sv
// rtl/fin_sync_edge.sv - fin synchronizer plus delay flop with rise/fall detection
module fin_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic fin,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], fin};
         r_dly  <= r_sync[SYNC_STAGES-1];
      end
   end

   assign lvl  = r_sync[SYNC_STAGES-1];
   assign rise = lvl & ~r_dly;
   assign fall = ~lvl & r_dly;

endmodule

// File: rtl/fin_period_meter.sv
// rtl/fin_period_meter.sv - fin period/half/high/low time meter with averaging and saturation
module fin_period_meter
   import fin_period_meter_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int AVG_LOG2    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fin,
   input  logic             enable,
   input  logic [1:0]       mode,
   output logic [CNT_W-1:0] count_N,
   output logic             valid,
   output logic             overflow,
   output logic             busy
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int WIN_W = AVG_LOG2 + 1;
   localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(2 ** AVG_LOG2);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t             r_state;
   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_acc;
   logic [WIN_W-1:0]   r_win;
   logic [CNT_W-1:0]   r_count;
   logic               r_valid;
   logic               r_ovf;

   logic               w_lvl;
   logic               w_rise;
   logic               w_fall;
   logic               w_start;
   logic               w_stop;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [ACC_W-1:0]   w_acc_next;
   logic [WIN_W-1:0]   w_win_next;
   logic [CNT_W-1:0]   w_avg;
   logic [CNT_W-1:0]   w_result;

   fin_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .fin  (fin),
      .lvl  (w_lvl),
      .rise (w_rise),
      .fall (w_fall)
   );

   assign w_start    = (r_mode == MODE_LOW)  ? w_fall : w_rise;
   assign w_stop     = (r_mode == MODE_HIGH) ? w_fall : w_rise;
   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_acc_next = r_acc + ACC_W'(w_cnt_inc);
   assign w_win_next = r_win + 1'b1;
   assign w_avg      = CNT_W'(w_acc_next >> AVG_LOG2);
   assign w_result   = (r_mode == MODE_HALF) ? (w_avg >> 1) : w_avg;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_mode  <= MODE_PERIOD;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_win   <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_win   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= ARM;
                  r_mode  <= mode;
                  r_cnt   <= '0;
               end
               ARM: begin
                  if (w_start) begin
                     r_state <= MEAS;
                     r_cnt   <= '0;
                  end
               end
               MEAS: begin
                  if (w_stop) begin
                     r_cnt <= '0;
                     if (w_win_next == WIN_FULL) begin
                        // Window done: the new mode applies from here; chain only if both are rise-to-rise.
                        r_count <= w_result;
                        r_valid <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_acc   <= '0;
                        r_win   <= '0;
                        r_mode  <= mode;
                        r_state <= (is_periodic(r_mode) && is_periodic(mode)) ? MEAS : ARM;
                     end else begin
                        r_acc   <= w_acc_next;
                        r_win   <= w_win_next;
                        r_state <= is_periodic(r_mode) ? MEAS : ARM;
                     end
                  end else if (w_cnt_inc == CNT_MAX) begin
                     r_count <= CNT_MAX;
                     r_ovf   <= 1'b1;
                     r_valid <= 1'b1;
                     r_acc   <= '0;
                     r_win   <= '0;
                     r_cnt   <= '0;
                     r_mode  <= mode;
                     r_state <= ARM;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign count_N  = r_count;
   assign valid    = r_valid;
   assign overflow = r_ovf;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_fin_period_meter.sv
// tb/tb_fin_period_meter.sv - scoreboard bench for fin_period_meter across three parameter sets
module tb_fin_period_meter;

   typedef struct packed {
      logic [15:0] cnt;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        fin;
   logic        en0, en1, en2;
   logic [1:0]  mode;

   logic [15:0] c0, c1;
   logic [7:0]  c2;
   logic        v0, v1, v2;
   logic        o0, o1, o2;
   logic        b0, b1, b2;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   vt0[$];
   int   nv1 = 0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   fin_period_meter #(.CNT_W(16), .AVG_LOG2(0), .SYNC_STAGES(2)) u0 (
      .clk(clk), .reset(reset), .fin(fin), .enable(en0), .mode(mode),
      .count_N(c0), .valid(v0), .overflow(o0), .busy(b0));

   fin_period_meter #(.CNT_W(16), .AVG_LOG2(2), .SYNC_STAGES(2)) u1 (
      .clk(clk), .reset(reset), .fin(fin), .enable(en1), .mode(mode),
      .count_N(c1), .valid(v1), .overflow(o1), .busy(b1));

   fin_period_meter #(.CNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(2)) u2 (
      .clk(clk), .reset(reset), .fin(fin), .enable(en2), .mode(mode),
      .count_N(c2), .valid(v2), .overflow(o2), .busy(b2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int cnt, input logic ovf);
      exp_t e;
      e.cnt = 16'(cnt);
      e.ovf = ovf;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && v0 === 1'b1) begin
         vt0.push_back(cyc);
         chk("u0_valid_expected", (q0.size() > 0), 1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u0_count", c0, e.cnt);
            chk("u0_ovf", o0, e.ovf);
         end
      end
      if (reset === 1'b0 && v1 === 1'b1) begin
         nv1++;
         chk("u1_valid_expected", (q1.size() > 0), 1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u1_count", c1, e.cnt);
            chk("u1_ovf", o1, e.ovf);
         end
      end
      if (reset === 1'b0 && v2 === 1'b1) begin
         chk("u2_valid_expected", (q2.size() > 0), 1);
         if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("u2_count", c2, e.cnt);
            chk("u2_ovf", o2, e.ovf);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int h, input int l);
      fin = 1'b1;
      tick(h);
      fin = 1'b0;
      tick(l);
   endtask

   task automatic close_and_stop();
      fin = 1'b1;
      tick(12);
      en0 = 1'b0;
      en1 = 1'b0;
      en2 = 1'b0;
      fin = 1'b0;
      tick(12);
   endtask

   initial begin
      int base;
      int nv_before;
      reset = 1'b1;
      fin   = 1'b0;
      en0   = 1'b0;
      en1   = 1'b0;
      en2   = 1'b0;
      mode  = 2'b00;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_count0", c0, 0);
      chk("rst_valid0", v0, 0);
      chk("rst_busy0", b0, 0);
      chk("rst_count2", c2, 0);
      chk("rst_ovf2", o2, 0);

      // reset in the middle of a measurement
      en0 = 1'b1;
      tick(5);
      q0.push_back(mk(20, 1'b0));
      drive_period(10, 10);
      fin = 1'b1;
      tick(12);
      chk("pre_rst_count0", c0, 20);
      tick(5);
      reset = 1'b1;
      en0   = 1'b0;
      tick(3);
      chk("mid_rst_count0", c0, 0);
      chk("mid_rst_valid0", v0, 0);
      chk("mid_rst_ovf0", o0, 0);
      chk("mid_rst_busy0", b0, 0);
      reset = 1'b0;
      fin   = 1'b0;
      tick(12);

      // enabled with a static fin: armed but never a result
      nv_before = vt0.size();
      en0 = 1'b1;
      tick(30);
      chk("idle_busy0", b0, 1);
      chk("idle_no_valid0", vt0.size(), nv_before);
      en0 = 1'b0;
      tick(3);

      // full period and half period, 10 high / 10 low
      for (int m = 0; m < 2; m++) begin
         mode = 2'(m);
         en0  = 1'b1;
         tick(5);
         base = vt0.size();
         for (int i = 0; i < 4; i++) q0.push_back(mk((m == 0) ? 20 : 10, 1'b0));
         for (int i = 0; i < 4; i++) drive_period(10, 10);
         fin = 1'b1;
         tick(12);
         chk("period_nresults", vt0.size() - base, 4);
         for (int i = 1; i < 4; i++)
            if (base + i < vt0.size())
               chk("period_interval", vt0[base+i] - vt0[base+i-1], 20);
         close_and_stop();
      end

      // high time then low time, 7 high / 13 low
      for (int m = 2; m < 4; m++) begin
         mode = 2'(m);
         en0  = 1'b1;
         tick(5);
         for (int i = 0; i < 4; i++) q0.push_back(mk((m == 2) ? 7 : 13, 1'b0));
         for (int i = 0; i < 4; i++) drive_period(7, 13);
         close_and_stop();
      end

      // averaging over four periods on the AVG_LOG2=2 instance
      mode = 2'b00;
      en1  = 1'b1;
      tick(5);
      q1.push_back(mk(11, 1'b0));
      drive_period(5, 5);
      drive_period(6, 6);
      drive_period(5, 5);
      drive_period(6, 6);
      close_and_stop();
      chk("avg_nresults", nv1, 1);

      // saturation on the CNT_W=8 instance, then recovery
      en2 = 1'b1;
      tick(5);
      q2.push_back(mk(255, 1'b1));
      fin = 1'b1;
      tick(5);
      fin = 1'b0;
      tick(280);
      chk("sat_seen", q2.size(), 0);
      chk("sat_ovf2", o2, 1);
      chk("sat_busy2", b2, 1);
      q2.push_back(mk(20, 1'b0));
      drive_period(10, 10);
      close_and_stop();
      chk("recover_ovf2", o2, 0);

      // enable dropped mid-period, then a fresh measurement
      mode = 2'b00;
      en0  = 1'b1;
      tick(5);
      fin = 1'b1;
      tick(8);
      en0 = 1'b0;
      tick(1);
      chk("abort_busy0", b0, 0);
      fin = 1'b0;
      tick(10);
      chk("abort_hold_count0", c0, 13);
      chk("abort_hold_ovf0", o0, 0);
      en0 = 1'b1;
      tick(5);
      q0.push_back(mk(20, 1'b0));
      drive_period(10, 10);
      close_and_stop();

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
